sa_skew_mover: RTL
==================

SA_SKEW_MOVER -- requirements
Module: sa_skew_mover

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per lane element.
REQ-002 SHALL have parameter PE_SIZE, default 14, meaning lane count and systolic array edge (legal range 2..64).
REQ-003 SHALL have parameter ROW_CNT_WIDTH, default 10, meaning the width of the tile row count.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle tile start request.
REQ-007 SHALL have port cfg_rows, input, ROW_CNT_WIDTH bits: input vectors in the tile, sampled on an accepted start.
REQ-008 SHALL have port in_valid / in_ready, input / output, 1 bit each: input vector handshake.
REQ-009 SHALL have port in_data, input, DATA_WIDTH*PE_SIZE bits: lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port out_valid / out_ready, output / input, 1 bit each: skewed vector handshake.
REQ-011 SHALL have port out_data, output, DATA_WIDTH*PE_SIZE bits, using the same lane packing as in_data.
REQ-012 SHALL have port busy, output, 1 bit, high from start acceptance until done.
REQ-013 SHALL have port done, output, 1 bit, a one-cycle pulse at tile completion.

Function
REQ-014 SHALL implement FSM states IDLE, FEED, DRAIN, DONE.
REQ-015 In IDLE, start with cfg_rows!=0 SHALL latch cfg_rows, clear the counters, and go to FEED; start with cfg_rows==0 SHALL be ignored.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 Advance condition: step = (!out_valid || out_ready); all lane delay lines and the output register SHALL shift only on step.
REQ-018 FEED: in_ready = step; each accepted beat SHALL load the output register and increment row_cnt.
REQ-019 The output register SHALL carry lane 0 = in_data lane 0, and lane k = in_data lane k accepted k beats earlier, or zero if no such beat exists in this tile.
REQ-020 The accept that makes row_cnt == latched rows SHALL move FEED to DRAIN.
REQ-021 DRAIN: in_ready = 0; each step SHALL load an output beat with zero injected at lane 0 and the delay lines shifting; exactly PE_SIZE-1 drain beats SHALL be produced, counted by drain_cnt.
REQ-022 After the last drain beat loads, the FSM SHALL enter DONE; DONE SHALL assert done for one cycle, drop busy, and return to IDLE.
REQ-023 Total output beats per tile SHALL be rows+PE_SIZE-1, beat t lane k = input beat (t-k) lane k when 0 <= t-k < rows, else 0.
REQ-024 Latency: accepted input to first out_valid SHALL be 1 cycle; there SHALL be no combinational path from in_data to out_data.
REQ-025 With out_ready held high, throughput SHALL be one beat per cycle, with no bubbles between FEED and DRAIN.
REQ-026 Backpressure: out_valid high with out_ready low SHALL hold out_data stable and deassert in_ready; no data SHALL be lost or duplicated.
REQ-027 The delay lines SHALL be cleared to zero on entering FEED, so that no data from a previous tile leaks into the new one.
REQ-028 The counters SHALL be wide enough for cfg_rows at its maximum value (2^ROW_CNT_WIDTH-1) and SHALL not wrap within a tile.

Reset
REQ-029 Asserting rst at any time, including mid-tile, SHALL asynchronously force state=IDLE, out_valid=0, out_data=0, in_ready=0, busy=0, done=0, all counters=0, and all delay lines=0.
REQ-030 The first start SHALL be accepted no earlier than the first rising edge after rst deasserts.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration (2-bit encoding) and the lane slice width constant.
REQ-032 One sub-module, sa_skew_lane (parameters DEPTH, DATA_WIDTH; ports clk, rst, step, clr, din, dout), SHALL implement the per-lane delay; it SHALL be instantiated for k = 1..PE_SIZE-1 with DEPTH = k, and lane 0 SHALL be a direct path.

Verification
REQ-033 PE_SIZE=4, rows=4, lane k of beat i = i+1, out_ready=1 -> 7 beats: lane0 = 1,2,3,4,0,0,0 and lane3 = 0,0,0,1,2,3,4; done is seen one cycle after the 7th beat loads.
REQ-034 Same stimulus with out_ready toggling 1,0 each cycle -> identical beat sequence, out_data stable while stalled, in_ready=0 whenever out_valid=1 and out_ready=0.
REQ-035 rows=1, PE_SIZE=14, value 8'hAA on all lanes -> 14 beats with exactly one nonzero lane per beat (beat t lane t = 8'hAA).
REQ-036 start with cfg_rows=0, and start pulsed during FEED -> no state change, busy unchanged, no extra beats produced.
REQ-037 rst asserted mid-DRAIN then a new tile rows=2 -> all outputs 0 during reset; the new tile's beats contain no residue from the first tile.
REQ-038 Back-to-back tiles (start issued in the cycle after done) -> the second tile's output matches the REQ-023 formula exactly.

Source files
------------

// File: rtl/sa_skew_mover_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sa_skew_mover_pkg
//  Purpose  : Shared constants for the systolic-array skew mover: FSM state
//             encoding and the default lane slice width.
//  Revision : 1.0 - initial release
// ============================================================================
package sa_skew_mover_pkg;

  // Default number of bits carried by one lane element.
  localparam int SKEW_LANE_W = 8;

  // Tile sequencer states, 2-bit encoding.
  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] skew_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage : sa_skew_mover_pkg
`default_nettype wire

// File: rtl/sa_skew_lane.sv
`default_nettype none
// ============================================================================
//  Module   : sa_skew_lane
//  Purpose  : Fixed-depth delay line for one lane of the skew mover. Shifts
//             only when the mover loads a new output beat, so stalls never
//             insert or drop elements.
//  Revision : 1.0 - initial release
// ============================================================================
module sa_skew_lane
  import sa_skew_mover_pkg::*;
#(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = SKEW_LANE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  // taps[i] holds the element entered i+1 shifts ago.
  logic [DATA_WIDTH-1:0] r_taps [DEPTH];

  // Shift register with async reset and synchronous clear; clear wins over step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_taps[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_taps[i] <= '0;
    end else if (step) begin
      r_taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_taps[i] <= r_taps[i-1];
    end
  end

  // Oldest element: the one entered DEPTH shifts before the current one.
  assign dout = r_taps[DEPTH-1];

endmodule : sa_skew_lane
`default_nettype wire

// File: rtl/sa_skew_mover.sv
`default_nettype none
// ============================================================================
//  Module   : sa_skew_mover
//  Purpose  : Turns a tile of row vectors into the diagonally skewed stream a
//             systolic array expects: lane k of each output beat is lane k of
//             the input beat accepted k beats earlier, zero-padded at both
//             ends of the tile (rows + PE_SIZE - 1 output beats per tile).
//  Revision : 1.0 - initial release
// ============================================================================
module sa_skew_mover
  import sa_skew_mover_pkg::*;
#(
  parameter int DATA_WIDTH    = SKEW_LANE_W,
  parameter int PE_SIZE       = 14,
  parameter int ROW_CNT_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROW_CNT_WIDTH-1:0]      cfg_rows,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH*PE_SIZE-1:0] out_data,
  output logic                          busy,
  output logic                          done
);

  localparam int BUS_W   = DATA_WIDTH * PE_SIZE;
  // Drain counter runs 0..PE_SIZE-1; this width holds that range.
  localparam int DRAIN_W = (PE_SIZE <= 2) ? 1 : $clog2(PE_SIZE);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PE_SIZE - 2);

  skew_state_t              r_state;
  logic [ROW_CNT_WIDTH-1:0] r_rows;
  logic [ROW_CNT_WIDTH-1:0] r_row_cnt;
  logic [DRAIN_W-1:0]       r_drain_cnt;
  logic                     r_out_valid;
  logic [BUS_W-1:0]         r_out_data;

  logic                     w_step;
  logic                     w_accept;
  logic                     w_drain_load;
  logic                     w_load;
  logic                     w_start_ok;
  logic                     w_last_row;
  logic                     w_last_drain;
  logic [BUS_W-1:0]         w_lane_in;
  logic [BUS_W-1:0]         w_next_out;

  // Output register may be refilled when empty or being consumed this cycle.
  assign w_step       = !r_out_valid || out_ready;
  assign in_ready     = (r_state == ST_FEED) && w_step;
  assign w_accept     = in_valid && in_ready;
  assign w_drain_load = (r_state == ST_DRAIN) && w_step;
  // A new output beat is produced: either a fresh input row or a drain beat.
  assign w_load       = w_accept || w_drain_load;
  assign w_start_ok   = (r_state == ST_IDLE) && start && (cfg_rows != '0);
  assign w_last_row   = (r_row_cnt + ROW_CNT_WIDTH'(1)) == r_rows;
  assign w_last_drain = r_drain_cnt == DRAIN_LAST;

  // During drain no row is accepted, so zeros enter every lane.
  assign w_lane_in = w_accept ? in_data : '0;

  // Lane 0 has no delay.
  assign w_next_out[DATA_WIDTH-1:0] = w_lane_in[DATA_WIDTH-1:0];

  // Lane k delays by k beats. The delay lines advance on output loads
  // (a subset of step cycles) so input gaps do not inject phantom elements.
  for (genvar k = 1; k < PE_SIZE; k++) begin : g_lane
    sa_skew_lane #(
      .DEPTH      (k),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .step (w_load),
      .clr  (w_start_ok),
      .din  (w_lane_in[k*DATA_WIDTH +: DATA_WIDTH]),
      .dout (w_next_out[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Tile sequencer: latch row count, count accepted rows, then drain beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rows      <= '0;
      r_row_cnt   <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_rows      <= cfg_rows;
            r_row_cnt   <= '0;
            r_drain_cnt <= '0;
            r_state     <= ST_FEED;
          end
        end
        ST_FEED: begin
          if (w_accept) begin
            r_row_cnt <= r_row_cnt + ROW_CNT_WIDTH'(1);
            if (w_last_row) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_load) begin
            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
            if (w_last_drain) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: load on a new beat, empty when consumed, hold when stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_next_out;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state == ST_FEED) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);

endmodule : sa_skew_mover
`default_nettype wire
